// File: rtl/mux_4x1_rr_arbiter_pkg.sv
// Shared definitions for the 4:1 round-robin mux arbiter: state encoding,
// requester count, select width and the rotating-priority pick function.
package mux_4x1_rr_arbiter_pkg;

    localparam int NREQ = 4;
    localparam int SELW = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    typedef struct packed {
        logic            valid;
        logic [SELW-1:0] idx;
    } pick_t;

    // First set request at or after ptr, wrapping 3->0; bits in excl are skipped.
    // Walks from the farthest offset back so the nearest candidate is kept last.
    function automatic pick_t rr_pick(input logic [NREQ-1:0] r,
                                      input logic [SELW-1:0] ptr,
                                      input logic [NREQ-1:0] excl);
        pick_t           res;
        logic [SELW-1:0] idx;
        res = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = ptr + SELW'(i);
            if (r[idx] && !excl[idx]) begin
                res.valid = 1'b1;
                res.idx   = idx;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/Mux_4x1.sv
// Existing single-bit 4:1 datapath mux; the arbiter is its only select source.
module Mux_4x1 (
    input  logic [3:0] I,
    input  logic [1:0] S,
    output logic       Y
);

    assign Y = I[S];

endmodule

// File: rtl/mux_4x1_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 mux among four requesters.
// Define MUX_ARB_QUANTUM_EN to enable tenure-limited preemption after QUANTUM cycles.
module mux_4x1_rr_arbiter
    import mux_4x1_rr_arbiter_pkg::*;
#(
    parameter int unsigned QUANTUM = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] din,
    output logic [NREQ-1:0] gnt,
    output logic [SELW-1:0] sel,
    output logic            busy,
    output logic            dout
);

    if (QUANTUM == 0 || QUANTUM > 16) begin : g_quantum_range
        $error("QUANTUM must be within 1..16");
    end

    state_t          state_reg, state_next;
    logic [NREQ-1:0] gnt_reg,   gnt_next;
    logic [SELW-1:0] sel_reg,   sel_next;
    logic [SELW-1:0] ptr_reg,   ptr_next;
    pick_t           pick_any;
    logic            take;
    logic [SELW-1:0] take_idx;
    logic            mux_y;

`ifdef MUX_ARB_QUANTUM_EN
    localparam int CNTW = 4;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(QUANTUM - 1);

    logic [CNTW-1:0] cnt_reg, cnt_next;
    pick_t           pick_other;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            gnt_reg   <= '0;
            sel_reg   <= '0;
            ptr_reg   <= '0;
`ifdef MUX_ARB_QUANTUM_EN
            cnt_reg   <= '0;
`endif
        end else begin
            state_reg <= state_next;
            gnt_reg   <= gnt_next;
            sel_reg   <= sel_next;
            ptr_reg   <= ptr_next;
`ifdef MUX_ARB_QUANTUM_EN
            cnt_reg   <= cnt_next;
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        gnt_next   = gnt_reg;
        sel_next   = sel_reg;
        ptr_next   = ptr_reg;
        take       = 1'b0;
        take_idx   = '0;
        pick_any   = rr_pick(req, ptr_reg, '0);
`ifdef MUX_ARB_QUANTUM_EN
        cnt_next   = cnt_reg;
        // gnt_reg is the one-hot owner, so it doubles as the exclusion mask.
        pick_other = rr_pick(req, ptr_reg, gnt_reg);
`endif

        case (state_reg)
            ST_IDLE: begin
                if (pick_any.valid) begin
                    take     = 1'b1;
                    take_idx = pick_any.idx;
                end
            end
            ST_GRANT: begin
                if (!req[sel_reg]) begin
                    // Release wins over quantum expiry and hands over without a bubble.
                    if (pick_any.valid) begin
                        take     = 1'b1;
                        take_idx = pick_any.idx;
                    end else begin
                        state_next = ST_IDLE;
                        gnt_next   = '0;
                        sel_next   = '0;
`ifdef MUX_ARB_QUANTUM_EN
                        cnt_next   = '0;
`endif
                    end
                end else begin
`ifdef MUX_ARB_QUANTUM_EN
                    if (cnt_reg == CNT_LAST) begin
                        if (pick_other.valid) begin
                            take     = 1'b1;
                            take_idx = pick_other.idx;
                        end else begin
                            cnt_next = '0;
                        end
                    end else begin
                        cnt_next = cnt_reg + CNTW'(1);
                    end
`endif
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (take) begin
            state_next = ST_GRANT;
            gnt_next   = NREQ'(1) << take_idx;
            sel_next   = take_idx;
            ptr_next   = take_idx + SELW'(1);
`ifdef MUX_ARB_QUANTUM_EN
            cnt_next   = '0;
`endif
        end
    end

    Mux_4x1 u_mux (
        .I (din),
        .S (sel_reg),
        .Y (mux_y)
    );

    assign gnt  = gnt_reg;
    assign sel  = sel_reg;
    assign busy = (state_reg == ST_GRANT);
    assign dout = mux_y & busy;

endmodule
